uart_protocol_host: RTL and testbench
=====================================

// Module: uart_protocol_host
// PURPOSE
// - Host-side initiator for the ASCII UART bus protocol: turns one bus request into a command string.
//   - Write: "L<aaaa>W<hh>". Read: "L<aaaa>R". Target reset: "," to assert, "." to release.
// - For reads, parses the two lowercase hex characters the target returns into a data byte.
// - Sits between a local request port (test sequencer or bridge) and a UART TX/RX pair.
// PARAMETERS
// - ADDR_CACHE      1       1: omit "L<aaaa>" when i_addr equals the tracked auto-incremented target address
// - TIMEOUT_CYCLES  100000  clocks allowed between read-response characters before abort; width = $clog2(TIMEOUT_CYCLES+1)
// PORTS
// - i_clk                 in   1   clock; single clock domain
// - i_reset               in   1   synchronous, active-high reset
// - i_req                 in   1   request valid; accepted only when o_ready=1
// - i_op                  in   2   0=read, 1=write, 2=assert target reset (','), 3=release target reset ('.')
// - i_addr                in   16  bus address (ops 0/1)
// - i_dat                 in   8   write data (op 1)
// - o_ready               out  1   idle, can accept a request
// - o_done                out  1   one-cycle pulse when the request completes
// - o_dat                 out  8   read data; valid from o_done (read) until the next read completes
// - o_timeout             out  1   one-cycle pulse, coincident with o_done, when a read aborted
// - i_uart_send_ready     in   1   TX can take a byte
// - o_uart_send_pulse     out  1   one-cycle strobe: o_uart_dat is taken this cycle
// - o_uart_dat            out  8   byte to transmit
// - i_uart_received_pulse in   1   RX byte strobe
// - i_uart_dat            in   8   received byte
// BEHAVIOUR
// Reset values
// - o_ready=1; o_done=0; o_timeout=0; o_uart_send_pulse=0.
// - o_dat=8'h00; address-valid flag=0; FSM in IDLE.
// Request handshake
// - i_req && o_ready latches op/addr/data in that cycle; o_ready drops the next cycle.
// TX handshake
// - o_uart_send_pulse = (FSM in a SEND_* state) && i_uart_send_ready, combinational.
// - o_uart_dat is valid whenever the FSM is in a SEND_* state.
// - The FSM advances on the same edge as the pulse; exactly one byte per pulse; no byte repeated or dropped.
// FSM states
// - IDLE: on accept -> SEND_RST for ops 2/3.
//   - Ops 0/1: -> SEND_CMD if (ADDR_CACHE && addr_valid && i_addr==tracked_addr), else -> SEND_L.
// - SEND_L: 'L' (0x4c) -> SEND_ADDR.
// - SEND_ADDR: 4 nibbles MSB first, 2-bit index 3..0 -> SEND_CMD.
// - SEND_CMD: 'W' (0x57) -> SEND_D (2 nibbles, hi then lo) -> DONE; or 'R' (0x52) -> WAIT_H.
// - SEND_RST: ',' (0x2c) or '.' (0x2e) -> DONE.
// - WAIT_H / WAIT_L: capture hex chars into o_dat[7:4] / [3:0]; WAIT_L -> DONE.
// - DONE: o_done=1 for one cycle -> IDLE, with o_ready=1 in the same cycle.
// Hex encoding and decoding
// - Encoding: nibble<10 -> nibble+0x30, else nibble+0x57 (lowercase).
// - Decoding: accept '0'-'9' and 'a'-'f' only.
// - Other received bytes are ignored in WAIT_*: no state change, but the timeout counter is still reloaded.
// - Received bytes outside WAIT_* are discarded.
// Address tracking
// - After a completed read or write: tracked_addr = addr+1, modulo 2^16 (0xffff -> 0x0000), addr_valid=1.
// - Ops 2/3 leave the tracking untouched.
// Timeout
// - Counter loads TIMEOUT_CYCLES on entry to WAIT_H and on every RX strobe; it decrements otherwise.
// - On reaching 0: o_timeout and o_done pulse together, o_dat is left unchanged, addr_valid=0, FSM -> IDLE.
// Simultaneous and mid-operation events
// - An RX strobe in the same cycle the counter reaches 0 takes priority: the character is consumed and there is no timeout.
// - i_reset at any point returns every register to its reset value in the next cycle.
//   - Any partially sent string is abandoned; its bytes are not re-sent.
// - i_req while o_ready=0 is ignored (not queued).
// STRUCTURE
// - Package uart_protocol_pkg:
//   - char constants CH_L, CH_W, CH_R, CH_RST_ASSERT, CH_RST_RELEASE;
//   - op encoding OP_READ/OP_WRITE/OP_RST_ASSERT/OP_RST_RELEASE;
//   - functions nibble_to_ascii, ascii_to_nibble, ascii_is_hex.
//   - The package is shared with the target-side decoder.
// - Sub-module uart_protocol_timeout: loadable down-counter with expiry flag.
// - Everything else is one FSM plus datapath in this file.
// TESTING
// Loopback bench: TX model with random i_uart_send_ready gaps; RX driven by a behavioural target model.
// 1. Write op=1, addr 0x1a00, dat 0x4d from reset -> TX "L1a00W4d"; one o_done; tracked_addr=0x1a01.
// 2. Then read op=0, addr 0x1a01 -> TX "R" only (no 'L'); target replies "c3" -> o_done with o_dat=0xc3.
// 3. Read addr 0xffff, then read addr 0x0000 -> 2nd sends "R" only; with ADDR_CACHE=0, "L0000R" is sent.
// 4. Read with target silent for TIMEOUT_CYCLES -> o_timeout and o_done on the same cycle; next request re-sends 'L'.
// 5. Read reply "x","3","Z","f" -> 'x' and 'Z' ignored; o_dat=0x3f.
//    Op 2 -> ','; op 3 -> '.'; tracked_addr unchanged.
// 6. i_reset asserted mid-"L1234" with send_ready held high -> no further TX pulse; o_ready=1 and addr_valid=0 next cycle.

Source files
------------

// File: rtl/uart_protocol_pkg.sv
// rtl/uart_protocol_pkg.sv - shared character, opcode and state definitions for the ASCII UART bus protocol
package uart_protocol_pkg;

  // Protocol characters
  localparam logic [7:0] CH_L           = 8'h4c;
  localparam logic [7:0] CH_W           = 8'h57;
  localparam logic [7:0] CH_R           = 8'h52;
  localparam logic [7:0] CH_RST_ASSERT  = 8'h2c;
  localparam logic [7:0] CH_RST_RELEASE = 8'h2e;

  // Request opcodes as presented on the local request port
  typedef enum logic [1:0] {
    OP_READ        = 2'd0,
    OP_WRITE       = 2'd1,
    OP_RST_ASSERT  = 2'd2,
    OP_RST_RELEASE = 2'd3
  } op_e;

  // Host initiator FSM states
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_SEND_L    = 4'd1,
    ST_SEND_ADDR = 4'd2,
    ST_SEND_CMD  = 4'd3,
    ST_SEND_D    = 4'd4,
    ST_SEND_RST  = 4'd5,
    ST_WAIT_H    = 4'd6,
    ST_WAIT_L    = 4'd7,
    ST_DONE      = 4'd8
  } host_state_e;

  // Lowercase hex digit for a nibble
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    logic [7:0] wide;
    wide = {4'h0, nib};
    return (nib < 4'd10) ? (wide + 8'h30) : (wide + 8'h57);
  endfunction

  // Only '0'-'9' and 'a'-'f' count as hex; uppercase is not part of the protocol
  function automatic logic ascii_is_hex(input logic [7:0] ch);
    return ((ch >= 8'h30) && (ch <= 8'h39)) || ((ch >= 8'h61) && (ch <= 8'h66));
  endfunction

  // Nibble value of a hex character; result is meaningless unless ascii_is_hex(ch)
  function automatic logic [3:0] ascii_to_nibble(input logic [7:0] ch);
    logic [7:0] val;
    if (ch <= 8'h39) val = ch - 8'h30;
    else             val = ch - 8'h57;
    return val[3:0];
  endfunction

endpackage

// File: rtl/uart_protocol_host_if.sv
// rtl/uart_protocol_host_if.sv - request port and UART TX/RX signals of the protocol host
interface uart_protocol_host_if;

  // Local request port
  logic        i_req;
  logic [1:0]  i_op;
  logic [15:0] i_addr;
  logic [7:0]  i_dat;
  logic        o_ready;
  logic        o_done;
  logic [7:0]  o_dat;
  logic        o_timeout;

  // UART byte side
  logic        i_uart_send_ready;
  logic        o_uart_send_pulse;
  logic [7:0]  o_uart_dat;
  logic        i_uart_received_pulse;
  logic [7:0]  i_uart_dat;

  // The protocol host itself
  modport slave (
    input  i_req, i_op, i_addr, i_dat,
    output o_ready, o_done, o_dat, o_timeout,
    input  i_uart_send_ready,
    output o_uart_send_pulse, o_uart_dat,
    input  i_uart_received_pulse, i_uart_dat
  );

  // Requester plus UART pair surrounding the host
  modport master (
    output i_req, i_op, i_addr, i_dat,
    input  o_ready, o_done, o_dat, o_timeout,
    output i_uart_send_ready,
    input  o_uart_send_pulse, o_uart_dat,
    output i_uart_received_pulse, i_uart_dat
  );

endinterface

// File: rtl/uart_protocol_timeout.sv
// rtl/uart_protocol_timeout.sv - loadable down-counter flagging when the read-response window has elapsed
module uart_protocol_timeout #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_count,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // Reload has priority over counting so a fresh character always restarts the window
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count <= '0;
    end else if (i_load) begin
      count <= CW'(TIMEOUT_CYCLES);
    end else if (i_count && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign o_expired = (count == '0);

endmodule

// File: rtl/uart_protocol_host.sv
// rtl/uart_protocol_host.sv - host initiator turning bus requests into ASCII UART command strings
module uart_protocol_host
  import uart_protocol_pkg::*;
#(
  parameter bit ADDR_CACHE     = 1'b1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  uart_protocol_host_if.slave bus
);

  host_state_e state;
  host_state_e state_nxt;
  host_state_e accept_state;

  op_e         op_q;
  logic [15:0] addr_q;
  logic [7:0]  dat_q;
  logic [1:0]  idx;
  logic [3:0]  hi_nib;
  logic [7:0]  rdat;
  logic [15:0] tracked_addr;
  logic        addr_valid;
  logic        to_flag;

  logic        accept;
  logic        send_state;
  logic        pulse;
  logic        rx;
  logic        rx_hex;
  logic        waiting;
  logic        expired;
  logic        timeout_hit;
  logic        cache_hit;
  logic        tmr_load;

  assign send_state  = (state == ST_SEND_L) || (state == ST_SEND_ADDR) || (state == ST_SEND_CMD) ||
                       (state == ST_SEND_D) || (state == ST_SEND_RST);
  assign pulse       = send_state && bus.i_uart_send_ready;
  assign accept      = bus.i_req && ((state == ST_IDLE) || (state == ST_DONE));
  assign rx          = bus.i_uart_received_pulse;
  assign rx_hex      = rx && ascii_is_hex(bus.i_uart_dat);
  assign waiting     = (state == ST_WAIT_H) || (state == ST_WAIT_L);
  // A character arriving on the expiry cycle wins over the timeout
  assign timeout_hit = waiting && expired && !rx;
  // The target auto-increments after each access, so a matching address needs no 'L' prefix
  assign cache_hit   = ADDR_CACHE && addr_valid && (bus.i_addr == tracked_addr);
  assign tmr_load    = ((state_nxt == ST_WAIT_H) && (state != ST_WAIT_H)) || rx;

  // Destination state for a freshly accepted request
  always_comb begin
    accept_state = ST_SEND_L;
    if (bus.i_op[1])    accept_state = ST_SEND_RST;
    else if (cache_hit) accept_state = ST_SEND_CMD;
  end

  uart_protocol_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (tmr_load),
    .i_count  (waiting),
    .o_expired(expired)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; send states only move on a TX pulse so each byte goes out exactly once
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: state_nxt = accept ? accept_state : ST_IDLE;
      ST_SEND_L:        if (pulse) state_nxt = ST_SEND_ADDR;
      ST_SEND_ADDR:     if (pulse && (idx == 2'd0)) state_nxt = ST_SEND_CMD;
      ST_SEND_CMD:      if (pulse) state_nxt = (op_q == OP_WRITE) ? ST_SEND_D : ST_WAIT_H;
      ST_SEND_D:        if (pulse && (idx == 2'd0)) state_nxt = ST_DONE;
      ST_SEND_RST:      if (pulse) state_nxt = ST_DONE;
      ST_WAIT_H: begin
        if (rx_hex)           state_nxt = ST_WAIT_L;
        else if (timeout_hit) state_nxt = ST_DONE;
      end
      ST_WAIT_L: begin
        if (rx_hex || timeout_hit) state_nxt = ST_DONE;
      end
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs and the byte presented to the transmitter
  always_comb begin
    bus.o_ready           = (state == ST_IDLE) || (state == ST_DONE);
    bus.o_done            = (state == ST_DONE);
    bus.o_timeout         = (state == ST_DONE) && to_flag;
    bus.o_uart_send_pulse = pulse;
    bus.o_uart_dat        = 8'h00;
    case (state)
      ST_SEND_L:    bus.o_uart_dat = CH_L;
      ST_SEND_ADDR: bus.o_uart_dat = nibble_to_ascii(addr_q[{idx, 2'b00} +: 4]);
      ST_SEND_CMD:  bus.o_uart_dat = (op_q == OP_WRITE) ? CH_W : CH_R;
      ST_SEND_D:    bus.o_uart_dat = nibble_to_ascii(dat_q[{idx[0], 2'b00} +: 4]);
      ST_SEND_RST:  bus.o_uart_dat = (op_q == OP_RST_ASSERT) ? CH_RST_ASSERT : CH_RST_RELEASE;
      default:      bus.o_uart_dat = 8'h00;
    endcase
  end

  assign bus.o_dat = rdat;

  // Request latch, nibble index, read data assembly and target address tracking
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      op_q         <= OP_READ;
      addr_q       <= 16'h0000;
      dat_q        <= 8'h00;
      idx          <= 2'd0;
      hi_nib       <= 4'h0;
      rdat         <= 8'h00;
      tracked_addr <= 16'h0000;
      addr_valid   <= 1'b0;
      to_flag      <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= op_e'(bus.i_op);
        addr_q  <= bus.i_addr;
        dat_q   <= bus.i_dat;
        to_flag <= 1'b0;
      end
      case (state)
        ST_SEND_L:    if (pulse) idx <= 2'd3;
        ST_SEND_ADDR: if (pulse) idx <= idx - 2'd1;
        ST_SEND_CMD:  if (pulse) idx <= 2'd1;
        ST_SEND_D: begin
          if (pulse) begin
            idx <= idx - 2'd1;
            if (idx == 2'd0) begin
              tracked_addr <= addr_q + 16'd1;
              addr_valid   <= 1'b1;
            end
          end
        end
        ST_WAIT_H: begin
          // The high nibble is held aside so an aborted read leaves o_dat untouched
          if (rx_hex) begin
            hi_nib <= ascii_to_nibble(bus.i_uart_dat);
          end else if (timeout_hit) begin
            to_flag    <= 1'b1;
            addr_valid <= 1'b0;
          end
        end
        ST_WAIT_L: begin
          if (rx_hex) begin
            rdat         <= {hi_nib, ascii_to_nibble(bus.i_uart_dat)};
            tracked_addr <= addr_q + 16'd1;
            addr_valid   <= 1'b1;
          end else if (timeout_hit) begin
            to_flag    <= 1'b1;
            addr_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_protocol_host.sv
// tb/tb_uart_protocol_host.sv - loopback bench for uart_protocol_host with directed vectors and a random reference-model phase
module tb_uart_protocol_host;

  localparam int T = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_protocol_host_if bus_a();
  uart_protocol_host_if bus_b();

  uart_protocol_host #(.ADDR_CACHE(1'b1), .TIMEOUT_CYCLES(T)) dut_a (
    .i_clk(clk), .i_reset(rst), .bus(bus_a)
  );
  uart_protocol_host #(.ADDR_CACHE(1'b0), .TIMEOUT_CYCLES(T)) dut_b (
    .i_clk(clk), .i_reset(rst), .bus(bus_b)
  );

  int errors = 0;
  int checks = 0;

  // Captured traffic
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int   done_a = 0;
  int   done_b = 0;
  int   stray_to = 0;
  logic last_to_a = 1'b0;
  bit   ready_rand = 1'b1;

  // Reference model of the host's address tracking and read data
  logic [15:0] m_tracked = 16'h0000;
  logic        m_valid = 1'b0;
  logic [7:0]  m_dat = 8'h00;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [7:0]  dat;
    string       reply;
    string       exp_tx;
    logic [7:0]  exp_dat;
    bit          exp_to;
  } vec_t;
  vec_t tbl[$];

  always @(negedge clk) begin
    if (bus_a.o_uart_send_pulse) q_a.push_back(bus_a.o_uart_dat);
    if (bus_b.o_uart_send_pulse) q_b.push_back(bus_b.o_uart_dat);
    if (bus_a.o_done) begin
      done_a    <= done_a + 1;
      last_to_a <= bus_a.o_timeout;
    end
    if (bus_b.o_done) done_b <= done_b + 1;
    if (bus_a.o_timeout && !bus_a.o_done) stray_to <= stray_to + 1;
  end

  // TX model: random back-pressure on A, B always ready
  initial begin
    bus_a.i_uart_send_ready = 1'b0;
    bus_b.i_uart_send_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus_a.i_uart_send_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  function automatic string q2s(input logic [7:0] q[$]);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%s", q[i])};
    return s;
  endfunction

  function automatic vec_t mk(input logic [1:0] op, input logic [15:0] addr, input logic [7:0] dat,
                              input string reply, input string exp_tx, input logic [7:0] exp_dat, input bit exp_to);
    vec_t v;
    v.op = op; v.addr = addr; v.dat = dat; v.reply = reply;
    v.exp_tx = exp_tx; v.exp_dat = exp_dat; v.exp_to = exp_to;
    return v;
  endfunction

  // Expected command string from the protocol rules
  function automatic string model_tx(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d);
    string s;
    s = "";
    if (op == 2'd2) return ",";
    if (op == 2'd3) return ".";
    if (!(m_valid && (a == m_tracked))) s = $sformatf("L%04h", a);
    if (op == 2'd1) s = {s, $sformatf("W%02h", d)};
    else            s = {s, "R"};
    return s;
  endfunction

  task automatic model_apply(input logic [1:0] op, input logic [15:0] a, input bit timed_out, input logic [7:0] rd);
    if (op < 2'd2) begin
      if (timed_out) begin
        m_valid = 1'b0;
      end else begin
        m_tracked = a + 16'd1;
        m_valid   = 1'b1;
        if (op == 2'd0) m_dat = rd;
      end
    end
  endtask

  task automatic send_reply_a(input string reply);
    for (int i = 0; i < reply.len(); i++) begin
      repeat ($urandom_range(1, 6)) @(negedge clk);
      bus_a.i_uart_received_pulse = 1'b1;
      bus_a.i_uart_dat = reply[i];
      @(negedge clk);
      bus_a.i_uart_received_pulse = 1'b0;
    end
  endtask

  task automatic run_a(input string tag, input logic [1:0] op, input logic [15:0] addr, input logic [7:0] dat,
                       input string reply, input string exp_tx, input logic [7:0] exp_dat, input bit exp_to);
    int n;
    int d0;
    n = 0;
    @(negedge clk);
    while (!bus_a.o_ready && n < 200) begin @(negedge clk); n++; end
    chk({tag, " ready"}, 32'(bus_a.o_ready), 32'd1);
    q_a.delete();
    d0 = done_a;
    bus_a.i_req = 1'b1; bus_a.i_op = op; bus_a.i_addr = addr; bus_a.i_dat = dat;
    @(posedge clk); #1;
    // Busy-cycle request with different contents must neither queue nor alter the latched one
    bus_a.i_op = 2'($urandom); bus_a.i_addr = 16'($urandom); bus_a.i_dat = 8'($urandom);
    @(posedge clk); #1;
    bus_a.i_req = 1'b0;
    n = 0;
    while (q_a.size() < exp_tx.len() && n < 400) begin @(negedge clk); n++; end
    send_reply_a(reply);
    n = 0;
    while (done_a == d0 && n < 3 * T + 100) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk({tag, " done count"}, 32'(done_a - d0), 32'd1);
    chk_str({tag, " tx"}, q2s(q_a), exp_tx);
    chk({tag, " timeout"}, 32'(last_to_a), 32'(exp_to));
    chk({tag, " o_dat"}, 32'(bus_a.o_dat), 32'(exp_dat));
  endtask

  task automatic run_b(input string tag, input logic [15:0] addr, input string reply,
                       input string exp_tx, input logic [7:0] exp_dat);
    int n;
    int d0;
    q_b.delete();
    d0 = done_b;
    @(negedge clk);
    bus_b.i_req = 1'b1; bus_b.i_op = 2'd0; bus_b.i_addr = addr;
    @(posedge clk); #1;
    bus_b.i_req = 1'b0;
    n = 0;
    while (q_b.size() < exp_tx.len() && n < 200) begin @(negedge clk); n++; end
    for (int i = 0; i < reply.len(); i++) begin
      repeat (2) @(negedge clk);
      bus_b.i_uart_received_pulse = 1'b1;
      bus_b.i_uart_dat = reply[i];
      @(negedge clk);
      bus_b.i_uart_received_pulse = 1'b0;
    end
    n = 0;
    while (done_b == d0 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk({tag, " done count"}, 32'(done_b - d0), 32'd1);
    chk_str({tag, " tx"}, q2s(q_b), exp_tx);
    chk({tag, " o_dat"}, 32'(bus_b.o_dat), 32'(exp_dat));
  endtask

  initial begin
    string js;
    string reply;
    string h;
    logic [1:0]  op;
    logic [15:0] addr;
    logic [7:0]  dat;
    logic [7:0]  v;
    bit          silent;
    int          n;
    int          d0;

    js = "gAZ:/`G@";
    rst = 1'b1;
    bus_a.i_req = 1'b0; bus_a.i_op = 2'd0; bus_a.i_addr = 16'h0; bus_a.i_dat = 8'h0;
    bus_a.i_uart_received_pulse = 1'b0; bus_a.i_uart_dat = 8'h0;
    bus_b.i_req = 1'b0; bus_b.i_op = 2'd0; bus_b.i_addr = 16'h0; bus_b.i_dat = 8'h0;
    bus_b.i_uart_received_pulse = 1'b0; bus_b.i_uart_dat = 8'h0;

    repeat (3) @(negedge clk);
    chk("reset o_ready", 32'(bus_a.o_ready), 32'd1);
    chk("reset o_done", 32'(bus_a.o_done), 32'd0);
    chk("reset o_timeout", 32'(bus_a.o_timeout), 32'd0);
    chk("reset send_pulse", 32'(bus_a.o_uart_send_pulse), 32'd0);
    chk("reset o_dat", 32'(bus_a.o_dat), 32'h00);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors from reset with ADDR_CACHE=1
    tbl.push_back(mk(2'd1, 16'h1a00, 8'h4d, "",     "L1a00W4d", 8'h00, 1'b0));
    tbl.push_back(mk(2'd0, 16'h1a01, 8'h00, "c3",   "R",        8'hc3, 1'b0));
    tbl.push_back(mk(2'd0, 16'hffff, 8'h00, "07",   "LffffR",   8'h07, 1'b0));
    tbl.push_back(mk(2'd0, 16'h0000, 8'h00, "e9",   "R",        8'he9, 1'b0));
    tbl.push_back(mk(2'd0, 16'h0001, 8'h00, "",     "R",        8'he9, 1'b1));
    tbl.push_back(mk(2'd0, 16'h0001, 8'h00, "x3Zf", "L0001R",   8'h3f, 1'b0));
    tbl.push_back(mk(2'd2, 16'h0002, 8'h00, "",     ",",        8'h3f, 1'b0));
    tbl.push_back(mk(2'd3, 16'h0002, 8'h00, "",     ".",        8'h3f, 1'b0));
    tbl.push_back(mk(2'd1, 16'h0002, 8'ha5, "",     "Wa5",      8'h3f, 1'b0));
    tbl.push_back(mk(2'd0, 16'h0003, 8'h00, "5",    "R",        8'h3f, 1'b1));
    tbl.push_back(mk(2'd1, 16'h0003, 8'hff, "",     "L0003Wff", 8'h3f, 1'b0));

    foreach (tbl[i]) begin
      run_a($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].dat, tbl[i].reply,
            tbl[i].exp_tx, tbl[i].exp_dat, tbl[i].exp_to);
      model_apply(tbl[i].op, tbl[i].addr, tbl[i].exp_to, tbl[i].exp_dat);
    end

    // Random requests against the reference model
    for (int k = 0; k < 40; k++) begin
      op = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      n = $urandom_range(0, 3);
      if (n < 2 && m_valid) addr = m_tracked;
      else if (n == 2)      addr = 16'hffff;
      else                  addr = 16'($urandom);
      dat = 8'($urandom);
      v = 8'($urandom);
      silent = (op == 2'd0) && ($urandom_range(0, 9) == 0);
      reply = "";
      if (op == 2'd0 && !silent) begin
        h = $sformatf("%02h", v);
        if ($urandom_range(0, 1) == 1) begin
          n = $urandom_range(0, js.len() - 1);
          reply = {reply, js.substr(n, n)};
        end
        reply = {reply, h.substr(0, 0)};
        if ($urandom_range(0, 1) == 1) begin
          n = $urandom_range(0, js.len() - 1);
          reply = {reply, js.substr(n, n)};
        end
        reply = {reply, h.substr(1, 1)};
      end
      run_a($sformatf("rnd%0d", k), op, addr, dat, reply, model_tx(op, addr, dat),
            (op == 2'd0 && !silent) ? v : m_dat, silent);
      model_apply(op, addr, silent, v);
    end
    chk("stray timeout", 32'(stray_to), 32'd0);

    // Reset in the middle of "L1234..." with the transmitter always ready
    ready_rand = 1'b0;
    @(negedge clk);
    d0 = done_a;
    q_a.delete();
    bus_a.i_req = 1'b1; bus_a.i_op = 2'd1; bus_a.i_addr = 16'h1234; bus_a.i_dat = 8'h5a;
    @(posedge clk); #1;
    bus_a.i_req = 1'b0;
    n = 0;
    while (q_a.size() < 3 && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q_a.delete();
    @(negedge clk);
    chk("mid-reset o_ready", 32'(bus_a.o_ready), 32'd1);
    chk("mid-reset o_dat", 32'(bus_a.o_dat), 32'h00);
    repeat (20) @(negedge clk);
    chk("mid-reset tx after", 32'(q_a.size()), 32'd0);
    chk("mid-reset done", 32'(done_a - d0), 32'd0);
    m_valid = 1'b0;
    m_dat = 8'h00;
    ready_rand = 1'b1;
    run_a("post-reset", 2'd0, m_tracked, 8'h00, "b2", model_tx(2'd0, m_tracked, 8'h00), 8'hb2, 1'b0);

    // Without the address cache every access carries the address
    run_b("nocache1", 16'hffff, "11", "LffffR", 8'h11);
    run_b("nocache2", 16'h0000, "2d", "L0000R", 8'h2d);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
